// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encodings, parity modes and parameter limits for the UART blocks
package uart_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;
    localparam logic [2:0] S_MARK   = 3'd6;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int CLKS_PER_BIT_MIN = 2;
    localparam int DATA_BITS_MIN    = 5;
    localparam int DATA_BITS_MAX    = 9;
    localparam int STOP_BITS_MIN    = 1;
    localparam int STOP_BITS_MAX    = 2;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - free-running bit-period counter with clear, flags the last cycle of each bit
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 1302,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic clear,
    output logic bit_end
);

    logic [CNT_W-1:0] cnt;

    assign bit_end = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            cnt <= '0;
        end else if (clear || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter; UART_TX_BREAK_EN adds line-break generation
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1302,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic                 i_Tx_DV,
    input  logic [DATA_BITS-1:0] i_Tx_Byte,
`ifdef UART_TX_BREAK_EN
    input  logic                 i_Tx_Break,
`endif
    output logic                 o_Tx_Ready,
    output logic                 o_Tx_Serial,
    output logic                 o_Tx_Active,
    output logic                 o_Tx_Done
);

    localparam int IDX_W      = $clog2(DATA_BITS);
    localparam bit HAS_PARITY = (PARITY_MODE != PARITY_NONE);

    if (CLKS_PER_BIT < CLKS_PER_BIT_MIN ||
        DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
        PARITY_MODE < PARITY_NONE || PARITY_MODE > PARITY_EVEN ||
        STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_param
        $error("uart_tx_cfg: parameter out of range");
    end

    logic [2:0]           state;
    logic [DATA_BITS-1:0] data_reg;
    logic                 parity_reg;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic                 done_reg;
    logic                 bit_end;
    logic                 timer_clear;
    logic                 last_stop;
    logic                 idle_ready;
    logic                 accept;
    logic                 par_in;
    logic                 tx_serial;

`ifdef UART_TX_BREAK_EN
    assign idle_ready  = (state == S_IDLE) && !i_Tx_Break;
    assign timer_clear = (state == S_IDLE) || (state == S_BREAK);
`else
    assign idle_ready  = (state == S_IDLE);
    assign timer_clear = (state == S_IDLE);
`endif

    assign last_stop   = (stop_idx == 1'(STOP_BITS - 1));
    // Ready also opens in the final stop cycle so a new word can start with no idle gap.
    assign o_Tx_Ready  = i_Rst_n && (idle_ready || ((state == S_STOP) && last_stop && bit_end));
    assign accept      = i_Tx_DV && o_Tx_Ready;
    assign par_in      = (PARITY_MODE == PARITY_EVEN) ? ^i_Tx_Byte : ~^i_Tx_Byte;
    assign o_Tx_Active = (state != S_IDLE);
    assign o_Tx_Done   = done_reg;
    assign o_Tx_Serial = tx_serial;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (CNT_W)
    ) u_timer (
        .i_Clock(i_Clock),
        .i_Rst_n(i_Rst_n),
        .clear  (timer_clear),
        .bit_end(bit_end)
    );

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state      <= S_IDLE;
            data_reg   <= '0;
            parity_reg <= 1'b0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                S_IDLE: begin
`ifdef UART_TX_BREAK_EN
                    if (i_Tx_Break) state <= S_BREAK;
`endif
                end
                S_START: if (bit_end) state <= S_DATA;
                S_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
                            state   <= HAS_PARITY ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                S_PARITY: if (bit_end) state <= S_STOP;
                S_STOP: begin
                    if (bit_end) begin
                        if (last_stop) begin
                            stop_idx <= 1'b0;
                            state    <= S_IDLE;
                            done_reg <= 1'b1;
                        end else begin
                            stop_idx <= stop_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_BREAK_EN
                S_BREAK: if (!i_Tx_Break) state <= S_MARK;
                S_MARK:  if (bit_end) state <= S_IDLE;
`endif
                default: state <= S_IDLE;
            endcase
            // Acceptance overrides the STOP->IDLE step for back-to-back frames.
            if (accept) begin
                data_reg   <= i_Tx_Byte;
                parity_reg <= par_in;
                state      <= S_START;
            end
        end
    end

    always_comb begin
        tx_serial = 1'b1;
        case (state)
            S_START:  tx_serial = 1'b0;
            S_DATA:   tx_serial = data_reg[bit_idx];
            S_PARITY: tx_serial = parity_reg;
`ifdef UART_TX_BREAK_EN
            S_BREAK:  tx_serial = 1'b0;
`endif
            default:  tx_serial = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - self-checking bench for uart_tx_cfg in 8N1, 7E2 and 8O1 builds
module tb_uart_tx_cfg;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dv[3];
    logic [7:0] tx_byte[3];
    logic       ser[3];
    logic       act[3];
    logic       rdy[3];
    logic       dn[3];
`ifdef UART_TX_BREAK_EN
    logic       brk[3];
`endif

    int checks = 0;
    int errors = 0;
    int db_a[3] = '{8, 7, 8};
    int pm_a[3] = '{0, 2, 1};
    int sb_a[3] = '{1, 2, 1};

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv[0]), .i_Tx_Byte(tx_byte[0]),
`ifdef UART_TX_BREAK_EN
        .i_Tx_Break(brk[0]),
`endif
        .o_Tx_Ready(rdy[0]), .o_Tx_Serial(ser[0]), .o_Tx_Active(act[0]), .o_Tx_Done(dn[0]));

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u_7e2 (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv[1]), .i_Tx_Byte(tx_byte[1][6:0]),
`ifdef UART_TX_BREAK_EN
        .i_Tx_Break(brk[1]),
`endif
        .o_Tx_Ready(rdy[1]), .o_Tx_Serial(ser[1]), .o_Tx_Active(act[1]), .o_Tx_Done(dn[1]));

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8o1 (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv[2]), .i_Tx_Byte(tx_byte[2]),
`ifdef UART_TX_BREAK_EN
        .i_Tx_Break(brk[2]),
`endif
        .o_Tx_Ready(rdy[2]), .o_Tx_Serial(ser[2]), .o_Tx_Active(act[2]), .o_Tx_Done(dn[2]));

    task automatic check(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Line level of bit slot b of a frame carrying word w, from the frame-format rules.
    function automatic logic exp_bit(int k, logic [7:0] w, int b);
        int n;
        logic [7:0] m;
        n = db_a[k];
        m = w & 8'((1 << n) - 1);
        if (b == 0) return 1'b0;
        if (b <= n) return w[b-1];
        if (pm_a[k] != 0 && b == n + 1) return (pm_a[k] == 2) ? ^m : ~^m;
        return 1'b1;
    endfunction

    function automatic int frame_cycles(int k);
        return CPB * (1 + db_a[k] + ((pm_a[k] != 0) ? 1 : 0) + sb_a[k]);
    endfunction

    // Entered at the first negedge after acceptance; checks every cycle of the frame.
    task automatic run_frame(int k, logic [7:0] w, bit first_done, bit chain, logic [7:0] nw);
        int len;
        len = frame_cycles(k);
        for (int c = 0; c < len; c++) begin
            check("serial", ser[k], exp_bit(k, w, c / CPB));
            check("active", act[k], 1'b1);
            check("ready", rdy[k], c == len - 1);
            check("done", dn[k], (c == 0) && first_done);
            if (c == len - 1) begin
                dv[k]      = chain;
                tx_byte[k] = nw;
            end else begin
                dv[k]      = 1'($urandom_range(0, 1));
                tx_byte[k] = 8'($urandom);
            end
            @(negedge clk);
        end
        if (!chain) begin
            check("done_pulse", dn[k], 1'b1);
            check("active_end", act[k], 1'b0);
            check("serial_end", ser[k], 1'b1);
            check("ready_end", rdy[k], 1'b1);
            @(negedge clk);
        end
    endtask

    task automatic idle(int k, int n);
        for (int i = 0; i < n; i++) begin
            check("idle_serial", ser[k], 1'b1);
            check("idle_ready", rdy[k], 1'b1);
            check("idle_active", act[k], 1'b0);
            check("idle_done", dn[k], 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic send(int k, logic [7:0] w);
        check("ready_pre", rdy[k], 1'b1);
        dv[k]      = 1'b1;
        tx_byte[k] = w;
        @(negedge clk);
        run_frame(k, w, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_b2b(int k, logic [7:0] w1, logic [7:0] w2);
        check("ready_pre", rdy[k], 1'b1);
        dv[k]      = 1'b1;
        tx_byte[k] = w1;
        @(negedge clk);
        run_frame(k, w1, 1'b0, 1'b1, w2);
        run_frame(k, w2, 1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            dv[k]      = 1'b0;
            tx_byte[k] = 8'h00;
`ifdef UART_TX_BREAK_EN
            brk[k]     = 1'b0;
`endif
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) idle(k, 1);

        send(0, 8'hA5);
        send(1, 8'h35);
        send(2, 8'h00);
        send(2, 8'hFF);
        send_b2b(0, 8'h55, 8'hC3);

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) begin
                send(k, 8'($urandom));
                idle(k, $urandom_range(0, 3));
            end
            send_b2b(k, 8'($urandom), 8'($urandom));
        end

        // Reset mid-DATA while the line is low.
        dv[0]      = 1'b1;
        tx_byte[0] = 8'h00;
        @(negedge clk);
        dv[0] = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_serial", ser[0], 1'b0);
        check("pre_rst_active", act[0], 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_serial", ser[0], 1'b1);
        check("rst_active", act[0], 1'b0);
        check("rst_done", dn[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", rdy[0], 1'b1);
        check("post_rst_active", act[0], 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("post_rst_done", dn[0], 1'b0);
            check("post_rst_serial", ser[0], 1'b1);
        end

`ifdef UART_TX_BREAK_EN
        brk[0]     = 1'b1;
        dv[0]      = 1'b1;
        tx_byte[0] = 8'h5A;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("brk_serial", ser[0], 1'b0);
            check("brk_ready", rdy[0], 1'b0);
            check("brk_active", act[0], 1'b1);
            check("brk_done", dn[0], 1'b0);
        end
        brk[0] = 1'b0;
        dv[0]  = 1'b0;
        for (int i = 0; i < CPB; i++) begin
            @(negedge clk);
            check("mark_serial", ser[0], 1'b1);
            check("mark_ready", rdy[0], 1'b0);
            check("mark_done", dn[0], 1'b0);
        end
        @(negedge clk);
        idle(0, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
